// File: rtl/route_reserve_allocator_pkg.sv
// Shared types for the route reservation allocator: port index width,
// port index type and the per-output FREE/HELD state encoding.
package router_alloc_pkg;

   // Default router radix; the allocator top may be re-parameterised.
   localparam int unsigned NUM_PORTS  = 5;
   localparam int unsigned PORT_IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   typedef logic [PORT_IDX_W-1:0] port_idx_t;

   typedef enum logic {
      FREE = 1'b0,
      HELD = 1'b1
   } alloc_state_e;

endpackage : router_alloc_pkg

// File: rtl/route_reserve_allocator_rr_arbiter.sv
// Per-output arbiter: picks one requester from an N-wide vector.
// ROUTE_ALLOC_ROUND_ROBIN_EN defined: search starts at ptr and the next
// pointer (winner+1 mod N) is offered to the caller. Undefined: fixed
// priority, lowest index wins, no pointer ports exist.
module rr_arbiter
   import router_alloc_pkg::*;
#(
   parameter int unsigned N     = NUM_PORTS,
   parameter int unsigned IDX_W = PORT_IDX_W
) (
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
   input  logic [IDX_W-1:0] ptr,
   output logic [IDX_W-1:0] nextPtr_c,
`endif
   input  logic [N-1:0]     req,
   output logic [N-1:0]     grant_c,
   output logic [IDX_W-1:0] grantIdx_c,
   output logic             grantValid_c
);

   // Scan requesters in priority order, first hit wins.
   always_comb begin
      int unsigned j;
      grant_c      = '0;
      grantIdx_c   = '0;
      grantValid_c = 1'b0;
      j            = 0;
      for (int unsigned k = 0; k < N; k++) begin
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
         j = 32'(ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
`else
         j = k;
`endif
         if (!grantValid_c && req[j]) begin
            grant_c[j]   = 1'b1;
            grantIdx_c   = IDX_W'(j);
            grantValid_c = 1'b1;
         end
      end
   end

`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
   // Priority restarts just after the winner.
   always_comb begin
      nextPtr_c = ptr;
      if (grantValid_c) begin
         nextPtr_c = (grantIdx_c == IDX_W'(N - 1)) ? '0 : grantIdx_c + IDX_W'(1);
      end
   end
`endif

endmodule : rr_arbiter

// File: rtl/route_reserve_allocator.sv
// Route reservation allocator: per-output FREE/HELD FSMs grant one
// requesting input per output, hold the reservation until the owner
// releases it, and drive crossbar select / busy / holding indications.
// Build option: ROUTE_ALLOC_ROUND_ROBIN_EN selects per-output round-robin
// arbitration; when undefined, fixed priority (lowest input wins).
module route_reserve_allocator
   import router_alloc_pkg::*;
#(
   parameter int unsigned PORTS         = NUM_PORTS,
   parameter int unsigned REQUEST_WIDTH = 3
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic [PORTS-1:0]                  req_valid,
   input  logic [PORTS*REQUEST_WIDTH-1:0]    req_port,
   input  logic [PORTS-1:0]                  route_release,
   output logic [PORTS-1:0]                  route_grant,
   output logic [PORTS-1:0]                  out_busy,
   output logic [PORTS*$clog2(PORTS)-1:0]    out_sel,
   output logic [PORTS-1:0]                  in_holding
);

   localparam int unsigned IDX_W = $clog2(PORTS);

   // Indexed [output][input].
   logic [PORTS-1:0][PORTS-1:0] elig_c;
   logic [PORTS-1:0][PORTS-1:0] arbGrant_c;
   logic [PORTS-1:0][IDX_W-1:0] arbIdx_c;
   logic [PORTS-1:0]            arbValid_c;

`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
   logic [PORTS-1:0][IDX_W-1:0] ptrQ;
   logic [PORTS-1:0][IDX_W-1:0] ptrD;
   logic [PORTS-1:0][IDX_W-1:0] arbNextPtr_c;
`endif

   alloc_state_e                stateQ [PORTS];
   alloc_state_e                stateD [PORTS];
   logic [PORTS-1:0][IDX_W-1:0] selQ;
   logic [PORTS-1:0][IDX_W-1:0] selD;
   logic [PORTS-1:0]            holdingQ;
   logic [PORTS-1:0]            holdingD;
   logic [PORTS-1:0]            grantQ;
   logic [PORTS-1:0]            grantD;

   // Eligible requests per output; holders and out-of-range ports never match.
   always_comb begin
      elig_c = '0;
      for (int unsigned o = 0; o < PORTS; o++) begin
         for (int unsigned i = 0; i < PORTS; i++) begin
            elig_c[o][i] = req_valid[i] && !holdingQ[i] &&
                           (req_port[i*REQUEST_WIDTH +: REQUEST_WIDTH] == REQUEST_WIDTH'(o));
         end
      end
   end

   // One arbiter per output, only fed while that output is FREE.
   for (genvar o = 0; o < PORTS; o++) begin : gArb
      logic [PORTS-1:0] arbReq;

      assign arbReq = (stateQ[o] == FREE) ? elig_c[o] : '0;

      rr_arbiter #(
         .N     (PORTS),
         .IDX_W (IDX_W)
      ) uArb (
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
         .ptr          (ptrQ[o]),
         .nextPtr_c    (arbNextPtr_c[o]),
`endif
         .req          (arbReq),
         .grant_c      (arbGrant_c[o]),
         .grantIdx_c   (arbIdx_c[o]),
         .grantValid_c (arbValid_c[o])
      );
   end

   // Next-state for every output FSM plus holding mask and grant pulses.
   always_comb begin
      stateD   = stateQ;
      selD     = selQ;
      holdingD = holdingQ;
      grantD   = '0;
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
      ptrD     = ptrQ;
`endif
      for (int unsigned o = 0; o < PORTS; o++) begin
         case (stateQ[o])
            FREE: begin
               if (arbValid_c[o]) begin
                  stateD[o] = HELD;
                  selD[o]   = arbIdx_c[o];
                  holdingD  = holdingD | arbGrant_c[o];
                  grantD    = grantD | arbGrant_c[o];
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
                  ptrD[o]   = arbNextPtr_c[o];
`endif
               end
            end
            HELD: begin
               // Only the owner's release counts; a release never re-arbitrates same cycle.
               for (int unsigned i = 0; i < PORTS; i++) begin
                  if ((selQ[o] == IDX_W'(i)) && route_release[i]) begin
                     stateD[o]   = FREE;
                     holdingD[i] = 1'b0;
                  end
               end
            end
            default: begin
               stateD[o] = FREE;
            end
         endcase
      end
   end

   // State registers; synchronous reset drops all reservations and in-flight grants.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned o = 0; o < PORTS; o++) begin
            stateQ[o] <= FREE;
         end
         selQ     <= '0;
         holdingQ <= '0;
         grantQ   <= '0;
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
         ptrQ     <= '0;
`endif
      end else begin
         for (int unsigned o = 0; o < PORTS; o++) begin
            stateQ[o] <= stateD[o];
         end
         selQ     <= selD;
         holdingQ <= holdingD;
         grantQ   <= grantD;
`ifdef ROUTE_ALLOC_ROUND_ROBIN_EN
         ptrQ     <= ptrD;
`endif
      end
   end

   // Busy is a direct decode of the registered FSM state.
   always_comb begin
      out_busy = '0;
      for (int unsigned o = 0; o < PORTS; o++) begin
         out_busy[o] = (stateQ[o] == HELD);
      end
   end

   assign route_grant = grantQ;
   assign out_sel     = selQ;
   assign in_holding  = holdingQ;

endmodule : route_reserve_allocator

// File: doc/route_reserve_allocator.md
# route_reserve_allocator

Switch-side allocator that sits directly downstream of every input port's head-flit buffer in a router. It accepts route-reservation requests (target output port) from all input ports and arbitrates per output port. It grants each winner with a one-cycle status pulse and holds the output reserved until the owning input releases it. It also drives the crossbar select and busy indication for each output.

## Interface
Parameters:
- `PORTS`, 5, number of input ports, equal to the number of output ports.
- `REQUEST_WIDTH`, 3, width of each request word; must be ≥ $clog2(PORTS).

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in PORTS: bit i high means input i requests a reservation.
- `req_port` in PORTS*REQUEST_WIDTH: slice i is the output port requested by input i.
- `route_release` in PORTS: bit i pulses to free the output held by input i.
- `route_grant` out PORTS: one-cycle grant pulse per input (routeReserveStatus).
- `out_busy` out PORTS: bit o high means output o is reserved.
- `out_sel` out PORTS*$clog2(PORTS): slice o is the input index owning output o.
- `in_holding` out PORTS: bit i high means input i currently owns an output.

## Operation
Each output port o runs an FSM with two states, FREE and HELD.
- FREE → HELD when at least one eligible request targets o.
  - Eligible means: `req_valid[i]`, `req_port[i]==o`, and `in_holding[i]==0`.
  - The winner is chosen by the arbitration policy (see Configuration).
  - On the transition: `out_sel[o]`←winner, `out_busy[o]`←1, `in_holding[winner]`←1, `route_grant[winner]`←1 for exactly one cycle.
- HELD → FREE when `route_release[out_sel[o]]` is high: `out_busy[o]`←0, `in_holding[owner]`←0.
- `route_release` on a non-holding input is ignored.

Requests are handled as follows:
- Requests with `req_port[i] ≥ PORTS` are ignored and never granted.
- A request to the input's own index is legal.
- An input whose `in_holding` bit is set is masked from all arbitration. This prevents a re-grant while the requester's `req_valid` is still high in the cycle of the grant pulse.
- Requests need not be held stable. A request dropped before its grant is simply not granted.
- Different outputs arbitrate independently. An input can be granted at most one output per cycle, and at most one output at a time.

Reset:
- All outputs FREE; `route_grant`, `out_busy`, `in_holding` = 0; `out_sel` = 0.
- Round-robin pointers = 0 (input 0 has highest priority first).

## Timing
- All outputs are registered.
- Grant latency: request sampled at edge t gives `route_grant` high during cycle t+1; `out_busy` and `out_sel` update at the same edge.
- Release: `route_release` sampled at edge t makes the output FREE during cycle t+1. A waiting request is granted at edge t+1, so its grant is visible in cycle t+2. There is no same-cycle release-to-grant bypass.
- Release and a new request from the same input in the same cycle: the release takes effect first. The input becomes eligible at t+1 and is granted at t+2 at the earliest.
- `rst` mid-operation drops all reservations at the next edge. Any grant pulse in flight is cancelled.

## Configuration
The macro `ROUTE_ALLOC_ROUND_ROBIN_EN` selects the arbitration policy.
- Defined: per-output round-robin. After a grant to input k, priority starts at (k+1) mod PORTS, and the pointer updates only on a grant.
- Undefined: fixed priority, with the lowest input index winning. No pointer state is instantiated.

## Structure
- Package `router_alloc_pkg` holds:
  - `PORT_IDX_W` localparam function of PORTS;
  - `port_idx_t` typedef;
  - FREE/HELD state enum `alloc_state_e`.
- Sub-module `rr_arbiter` (PORTS-wide request vector in; one-hot grant, index, and pointer update out) is instantiated once per output port.
- Per-output FSMs and the input-holding mask live in the top module.

## Test plan
- Single request: input 2 requests output 4 at t=0 → `route_grant[2]`=1 in cycle 1 only, `out_busy[4]`=1, `out_sel[4]`=2, `in_holding[2]`=1.
- Contention, round-robin: inputs 0, 1 and 3 request output 2 simultaneously → grants go to 0, then 1, then 3. Each next grant arrives 2 cycles after the previous owner's release. With the macro undefined, the order is 0, 1, 3 as well, but after 0 re-requests it beats 3.
- Held request: input 1 keeps `req_valid` high for 5 cycles after its grant → exactly one grant pulse; no second grant until release and re-request.
- Parallel outputs: input 0→3 and input 4→1 at t=0 → both granted in cycle 1; both `out_busy` bits set.
- Illegal and stray: `req_port`=6 on input 2 → no grant, state unchanged. `route_release[3]` while input 3 holds nothing → no change.
- Reset mid-hold: output 2 HELD by input 1, then `rst` pulse → all `out_busy`/`in_holding`=0 next cycle. A still-asserted request from input 1 is granted 2 cycles after `rst` deasserts.
